// File: rtl/msf_pkg.sv
// MSF time-code shared definitions: frame bit positions, marker length, time record.
// Latency: n/a (package only).
// Backpressure: n/a. Shared by the transmit encoder and the receiver/decoder.
package msf_pkg;

    // A-bit positions, MSB of each field first (lowest second index = MSB)
    localparam int YEAR_MSB   = 17;
    localparam int YEAR_LSB   = 24;
    localparam int MONTH_MSB  = 25;
    localparam int MONTH_LSB  = 29;
    localparam int MDAY_MSB   = 30;
    localparam int MDAY_LSB   = 35;
    localparam int WDAY_MSB   = 36;
    localparam int WDAY_LSB   = 38;
    localparam int HOUR_MSB   = 39;
    localparam int HOUR_LSB   = 44;
    localparam int MINUTE_MSB = 45;
    localparam int MINUTE_LSB = 51;

    // Fixed A52..A59 tail; bit 7 is A52, bit 0 is A59
    localparam int         TAIL_LSB     = 59;
    localparam logic [7:0] TAIL_PATTERN = 8'b0111_1110;

    // B-bit positions
    localparam int PAR_YEAR = 54;
    localparam int PAR_DATE = 55;  // month + day of month
    localparam int PAR_WDAY = 56;
    localparam int PAR_TIME = 57;  // hour + minute
    localparam int BST      = 58;

    localparam int MARKER_TENTHS   = 5;
    localparam int SECONDS_PER_MIN = 60;

    typedef struct packed {
        logic [7:0] year;
        logic [4:0] month;
        logic [5:0] mday;
        logic [2:0] wday;
        logic [5:0] hour;
        logic [6:0] minute;
        logic       bst;
    } msf_time_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } msf_tx_state_e;

    // Odd parity bit: field ones + parity ones is odd. Zero-extension is harmless.
    function automatic logic odd_par(input logic [15:0] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/msf_bit_lut.sv
// MSF bit map: returns the A and B bits for a given second of the frame.
// Latency: combinational.
// Backpressure: none.
// Ports: sec_i (second 0-59), time_i (active time record) -> a_o, b_o.
module msf_bit_lut
    import msf_pkg::*;
(
    input  logic [5:0] sec_i,
    input  msf_time_t  time_i,
    output logic       a_o,
    output logic       b_o
);

    // 64 entries so every 6-bit index is in range; 60..63 and 0 stay zero
    logic [63:0] a_map;
    logic [63:0] b_map;

    always_comb begin
        a_map = '0;
        b_map = '0;

        for (int i = 0; i <= YEAR_LSB - YEAR_MSB; i++)
            a_map[YEAR_LSB - i] = time_i.year[i];
        for (int i = 0; i <= MONTH_LSB - MONTH_MSB; i++)
            a_map[MONTH_LSB - i] = time_i.month[i];
        for (int i = 0; i <= MDAY_LSB - MDAY_MSB; i++)
            a_map[MDAY_LSB - i] = time_i.mday[i];
        for (int i = 0; i <= WDAY_LSB - WDAY_MSB; i++)
            a_map[WDAY_LSB - i] = time_i.wday[i];
        for (int i = 0; i <= HOUR_LSB - HOUR_MSB; i++)
            a_map[HOUR_LSB - i] = time_i.hour[i];
        for (int i = 0; i <= MINUTE_LSB - MINUTE_MSB; i++)
            a_map[MINUTE_LSB - i] = time_i.minute[i];
        for (int i = 0; i < 8; i++)
            a_map[TAIL_LSB - i] = TAIL_PATTERN[i];

        b_map[PAR_YEAR] = odd_par(16'(time_i.year));
        b_map[PAR_DATE] = odd_par(16'({time_i.month, time_i.mday}));
        b_map[PAR_WDAY] = odd_par(16'(time_i.wday));
        b_map[PAR_TIME] = odd_par(16'({time_i.hour, time_i.minute}));
        b_map[BST]      = time_i.bst;
    end

    assign a_o = a_map[sec_i];
    assign b_o = b_map[sec_i];

endmodule

// File: rtl/msf_tx_encoder.sv
// MSF 60 kHz envelope generator (data_o=1 means carrier off) from latched BCD time.
// Latency: data_o is registered, one cycle behind the tick/tenth/second counters.
// Backpressure: none; free-running once enabled, frame repeats until a new load.
// Ports: clk_i, rst_i (sync, active high), enable_i, load_i + time fields in;
//        data_o, second_o (0-59), minute_start_o (pulse on first cycle of second 0) out.
module msf_tx_encoder
    import msf_pkg::*;
#(
    parameter int TICKS_PER_TENTH = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       enable_i,
    input  logic       load_i,
    input  logic [7:0] year_i,
    input  logic [4:0] month_i,
    input  logic [5:0] mday_i,
    input  logic [2:0] wday_i,
    input  logic [5:0] hour_i,
    input  logic [6:0] minute_i,
    input  logic       bst_i,
    output logic       data_o,
    output logic [5:0] second_o,
    output logic       minute_start_o
);

    localparam int            TW        = (TICKS_PER_TENTH > 1) ? $clog2(TICKS_PER_TENTH) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_TENTH - 1);

    msf_tx_state_e state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    tenth_q, tenth_d;
    logic [5:0]    sec_q, sec_d;
    logic          data_q, data_d;
    msf_time_t     shadow_q, shadow_d;
    msf_time_t     active_q, active_d;

    msf_time_t     in_time;
    logic          minute_start;
    logic          running;
    logic          level;
    logic          lut_a, lut_b;

    assign in_time = {year_i, month_i, mday_i, wday_i, hour_i, minute_i, bst_i};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_i)  state_d = ST_RUN;
            ST_RUN:  if (!enable_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic. A cycle where enable_i has just dropped counts as not running,
    // so the first IDLE cycle already shows data_o=0 and zeroed counters.
    always_comb begin
        running      = (state_q == ST_RUN) && enable_i;
        minute_start = (state_q == ST_RUN) && (tick_q == '0) && (tenth_q == '0) && (sec_q == '0);
    end

    // Tick / tenth / second counters; held at zero whenever not running
    always_comb begin
        tick_d  = '0;
        tenth_d = '0;
        sec_d   = '0;
        if (running) begin
            tick_d  = tick_q + TW'(1);
            tenth_d = tenth_q;
            sec_d   = sec_q;
            if (tick_q == TICK_LAST) begin
                tick_d  = '0;
                tenth_d = tenth_q + 4'd1;
                if (tenth_q == 4'd9) begin
                    tenth_d = '0;
                    sec_d   = (sec_q == 6'(SECONDS_PER_MIN - 1)) ? 6'd0 : sec_q + 6'd1;
                end
            end
        end
    end

    msf_bit_lut u_bit_lut (
        .sec_i  (sec_q),
        .time_i (active_q),
        .a_o    (lut_a),
        .b_o    (lut_b)
    );

    // Envelope level for the current slot
    always_comb begin
        level = 1'b0;
        if (sec_q == '0) begin
            level = (tenth_q < 4'(MARKER_TENTHS));
        end else begin
            case (tenth_q)
                4'd0:    level = 1'b1;
                4'd1:    level = lut_a;
                4'd2:    level = lut_b;
                default: level = 1'b0;
            endcase
        end
        data_d = running ? level : 1'b0;
    end

    // Shadow/active time registers. A load coinciding with the minute boundary
    // bypasses the shadow so the new time is used in the frame that starts now.
    always_comb begin
        shadow_d = load_i ? in_time : shadow_q;
        active_d = active_q;
        if (minute_start)
            active_d = load_i ? in_time : shadow_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_q   <= '0;
            tenth_q  <= '0;
            sec_q    <= '0;
            data_q   <= 1'b0;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            tick_q   <= tick_d;
            tenth_q  <= tenth_d;
            sec_q    <= sec_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign data_o         = data_q;
    assign second_o       = sec_q;
    assign minute_start_o = minute_start;

endmodule

// File: tb/tb_msf_tx_encoder.sv
module tb_msf_tx_encoder;
    import msf_pkg::*;

    localparam int TPT     = 4;
    localparam int CPS     = TPT * 10;      // cycles per second
    localparam int FRAME   = CPS * 60;      // cycles per frame
    localparam int MARK    = MARKER_TENTHS * TPT;

    logic       clk = 1'b0;
    logic       rst_i, enable_i, load_i;
    logic [7:0] year_i;
    logic [4:0] month_i;
    logic [5:0] mday_i;
    logic [2:0] wday_i;
    logic [5:0] hour_i;
    logic [6:0] minute_i;
    logic       bst_i;
    logic       data_o;
    logic [5:0] second_o;
    logic       minute_start_o;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    msf_time_t t1, t2, t3, tz;

    msf_tx_encoder #(.TICKS_PER_TENTH(TPT)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .load_i         (load_i),
        .year_i         (year_i),
        .month_i        (month_i),
        .mday_i         (mday_i),
        .wday_i         (wday_i),
        .hour_i         (hour_i),
        .minute_i       (minute_i),
        .bst_i          (bst_i),
        .data_o         (data_o),
        .second_o       (second_o),
        .minute_start_o (minute_start_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected 10-tenth pattern of one second; bit t = level in tenth t
    function automatic logic [9:0] expect_second(input msf_time_t t, input int s);
        logic [58:0] a_bits;   // bit 58 = A1 ... bit 0 = A59
        logic [58:0] b_bits;
        logic [9:0]  p;
        a_bits = {16'h0, t.year, t.month, t.mday, t.wday, t.hour, t.minute, 8'b0111_1110};
        b_bits = {53'h0, ~^t.year, ~^{t.month, t.mday}, ~^t.wday, ~^{t.hour, t.minute},
                  t.bst, 1'b0};
        p = '0;
        if (s == 0) begin
            p = 10'b00000_11111;
        end else begin
            p[0] = 1'b1;
            p[1] = a_bits[59 - s];
            p[2] = b_bits[59 - s];
        end
        return p;
    endfunction

    task automatic push_frame(input msf_time_t t);
        for (int s = 0; s < 60; s++) exp_q.push_back(expect_second(t, s));
    endtask

    task automatic drive_time(input msf_time_t t);
        year_i   = t.year;
        month_i  = t.month;
        mday_i   = t.mday;
        wday_i   = t.wday;
        hour_i   = t.hour;
        minute_i = t.minute;
        bst_i    = t.bst;
    endtask

    task automatic wait_pulse();
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!minute_start_o && c < FRAME + 100);
        check("minute_start_wait", 32'(minute_start_o), 32'd1);
    endtask

    // Called on the negedge of the minute_start_o cycle (n=0). Data for slot
    // (s,t,k) appears in cycle n = 1 + s*CPS + t*TPT + k.
    task automatic capture_frame(input bit do_load, input int load_n, input msf_time_t ld);
        logic [9:0] pat;
        logic [9:0] exp;
        int s, t, k, hi, lo;
        pat = '0;
        hi  = 0;
        lo  = 0;
        for (int n = 0; n < FRAME; n++) begin
            if (n > 0) @(negedge clk);
            load_i = 1'b0;
            if (do_load && n == load_n) begin
                drive_time(ld);
                load_i = 1'b1;
                push_frame(ld);
            end
            if (n >= 1) begin
                s = (n - 1) / CPS;
                t = ((n - 1) % CPS) / TPT;
                k = (n - 1) % TPT;
                if (n <= MARK)          hi += int'(data_o);
                else if (n <= 2 * MARK) lo += int'(data_o);
                if (n == 2 * MARK) begin
                    check("marker_high_cycles", 32'(hi), 32'(MARK));
                    check("marker_low_cycles", 32'(lo), 32'd0);
                end
                if (k == 2) pat[t] = data_o;
                if (k == 2 && t == 5) check($sformatf("second_o_s%0d", s), 32'(second_o), 32'(s));
                if (k == 2 && t == 9) begin
                    // 10'h3ff can never occur (tenths 3-9 are always 0)
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
                    check($sformatf("pattern_s%0d", s), 32'(pat), 32'(exp));
                    pat = '0;
                end
            end
        end
        load_i = 1'b0;
    endtask

    initial begin
        t1 = '{year: 8'h24, month: 5'h03, mday: 6'h15, wday: 3'd5,
               hour: 6'h13, minute: 7'h47, bst: 1'b0};
        t2 = '{year: 8'h24, month: 5'h03, mday: 6'h15, wday: 3'd5,
               hour: 6'h13, minute: 7'h48, bst: 1'b1};
        t3 = '{year: 8'h99, month: 5'h12, mday: 6'h31, wday: 3'd6,
               hour: 6'h23, minute: 7'h59, bst: 1'b1};
        tz = '0;

        rst_i    = 1'b1;
        enable_i = 1'b0;
        load_i   = 1'b0;
        drive_time(tz);
        repeat (3) @(negedge clk);
        check("reset_data", 32'(data_o), 32'd0);
        check("reset_second", 32'(second_o), 32'd0);
        check("reset_pulse", 32'(minute_start_o), 32'd0);

        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_data", 32'(data_o), 32'd0);

        // Load while idle; first frame must use it
        drive_time(t1);
        load_i = 1'b1;
        push_frame(t1);
        @(negedge clk);
        load_i = 1'b0;
        @(negedge clk);

        enable_i = 1'b1;
        @(negedge clk);
        check("first_run_pulse", 32'(minute_start_o), 32'd1);
        check("first_run_second", 32'(second_o), 32'd0);
        check("first_run_data_latency", 32'(data_o), 32'd0);

        // Frame 1: t1, with t2 loaded mid-frame (must not affect this frame)
        capture_frame(1'b1, 1000, t2);
        // Frame 2: t2
        wait_pulse();
        capture_frame(1'b0, 0, tz);
        // Frame 3: t3 loaded on the minute_start cycle itself
        wait_pulse();
        capture_frame(1'b1, 0, t3);
        // Frame 4: no load, t3 repeats
        wait_pulse();
        push_frame(t3);
        capture_frame(1'b0, 0, tz);

        // Frame 5: drop enable at second 30, tenth 1
        wait_pulse();
        repeat (30 * CPS + TPT) @(negedge clk);
        check("pre_disable_second", 32'(second_o), 32'd30);
        check("pre_disable_data", 32'(data_o), 32'd1);
        enable_i = 1'b0;
        @(negedge clk);
        check("disable_data", 32'(data_o), 32'd0);
        check("disable_second", 32'(second_o), 32'd0);
        check("disable_pulse", 32'(minute_start_o), 32'd0);
        repeat (5) @(negedge clk);
        check("idle_hold_data", 32'(data_o), 32'd0);
        check("idle_hold_second", 32'(second_o), 32'd0);

        enable_i = 1'b1;
        @(negedge clk);
        check("reenable_pulse", 32'(minute_start_o), 32'd1);
        check("reenable_second", 32'(second_o), 32'd0);

        // Reset during the second-0 marker
        repeat (10) @(negedge clk);
        check("marker_before_reset", 32'(data_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        check("reset_mid_data", 32'(data_o), 32'd0);
        check("reset_mid_second", 32'(second_o), 32'd0);
        check("reset_mid_pulse", 32'(minute_start_o), 32'd0);
        rst_i = 1'b0;

        // Active and shadow registers were cleared: frame carries all-zero time
        push_frame(tz);
        wait_pulse();
        capture_frame(1'b0, 0, tz);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
